// File: rtl/core_inst_seq.sv
// Tile-pass instruction sequencer: emits one registered 35-bit core instruction
// per cycle covering weight fetch/load, activation fetch/execute and output drain.
module core_inst_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [addr_bw-1:0] len,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               busy,
  output logic               done
);

  localparam int CW = addr_bw + 2;
  typedef logic [CW-1:0] cnt_t;
  localparam logic [34:0]        IDLE_WORD = 35'h1_800C_0000;
  localparam logic [addr_bw-1:0] ONE_A     = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_W_XRD, S_W_LOAD, S_X_XRD, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t             state, nxt_state;
  cnt_t               k, nxt_k;
  logic [addr_bw-1:0] w_q, x_q, p_q, len_q;
  logic [addr_bw-1:0] rd_cnt, wr_cnt;
  logic [addr_bw-1:0] w_eff;
  logic               rd_now, wr_now;
  logic [34:0]        nxt_inst;

  always_comb begin
    nxt_state = state;
    nxt_k     = k + cnt_t'(1);
    unique case (state)
      S_IDLE: begin
        nxt_k = '0;
        if (start) nxt_state = S_W_XRD;
      end
      S_W_XRD:
        if (k == cnt_t'(col)) begin
          nxt_state = S_W_LOAD;
          nxt_k     = '0;
        end
      S_W_LOAD:
        if (k == cnt_t'(col + row - 1)) begin
          nxt_state = (len_q == '0) ? S_DONE : S_X_XRD;
          nxt_k     = '0;
        end
      S_X_XRD:
        if (k == cnt_t'(len_q)) begin
          nxt_state = S_EXEC;
          nxt_k     = '0;
        end
      S_EXEC:
        if (k == cnt_t'(len_q) + cnt_t'(row + col - 1)) begin
          nxt_state = S_DRAIN;
          nxt_k     = '0;
        end
      S_DRAIN: begin
        nxt_k = '0;
        if (wr_cnt == len_q) nxt_state = S_DONE;
      end
      S_DONE: begin
        nxt_k     = '0;
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_k     = '0;
        nxt_state = S_IDLE;
      end
    endcase
  end

  // The instruction is built from next-state values so the registered word
  // lines up with the state it belongs to; bases are not yet latched on the
  // accepting edge, so the first weight address comes straight from the port.
  always_comb begin
    w_eff    = (state == S_IDLE) ? w_base : w_q;
    rd_now   = (nxt_state == S_DRAIN) && ofifo_valid && (rd_cnt < len_q);
    wr_now   = (state == S_DRAIN) && inst[6];
    nxt_inst = IDLE_WORD;
    unique case (nxt_state)
      S_W_XRD: begin
        if (nxt_k < cnt_t'(col)) begin
          nxt_inst[19]            = 1'b0;
          nxt_inst[7 +: addr_bw]  = w_eff + nxt_k[addr_bw-1:0];
        end
        if (nxt_k != '0) nxt_inst[2] = 1'b1;
      end
      S_W_LOAD: begin
        nxt_inst[1:0] = 2'b01;
        if (nxt_k < cnt_t'(col)) nxt_inst[3] = 1'b1;
      end
      S_X_XRD: begin
        if (nxt_k < cnt_t'(len_q)) begin
          nxt_inst[19]            = 1'b0;
          nxt_inst[7 +: addr_bw]  = x_q + nxt_k[addr_bw-1:0];
        end
        if (nxt_k != '0) nxt_inst[2] = 1'b1;
      end
      S_EXEC: begin
        nxt_inst[1:0] = 2'b10;
        if (nxt_k < cnt_t'(len_q)) nxt_inst[3] = 1'b1;
      end
      S_DRAIN: begin
        nxt_inst[6] = rd_now;
        if (wr_now) begin
          nxt_inst[32]            = 1'b0;
          nxt_inst[31]            = 1'b0;
          nxt_inst[20 +: addr_bw] = p_q + wr_cnt;
        end
      end
      default: nxt_inst = IDLE_WORD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      k      <= '0;
      w_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      inst   <= IDLE_WORD;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= nxt_state;
      k     <= nxt_k;
      inst  <= nxt_inst;
      busy  <= (nxt_state != S_IDLE);
      done  <= (nxt_state == S_DONE);
      if (state == S_IDLE && start) begin
        w_q    <= w_base;
        x_q    <= x_base;
        p_q    <= p_base;
        len_q  <= len;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_now) rd_cnt <= rd_cnt + ONE_A;
        if (wr_now) wr_cnt <= wr_cnt + ONE_A;
      end
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: table of tile passes plus hand sequences
// for mid-pass reset and DRAIN back-pressure, with a per-cycle protocol monitor.
module tb_core_inst_seq;

  localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base, x_base, p_base, len;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy, done;

  core_inst_seq #(.row(8), .col(8), .addr_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .len(len),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: cumulative counters, the stimulus side only snapshots them.
  logic [10:0] xq[$];
  logic [10:0] pq[$];
  int   viol = 0, rd_n = 0, done_n = 0, busy_n = 0;
  logic rd_prev = 1'b0;
  logic v_at_edge = 1'b1;

  always @(posedge clk) v_at_edge = ofifo_valid;

  always @(negedge clk) begin
    logic x_rd, x_wr, p_wr;
    x_rd = !inst[19] && inst[18];
    x_wr = !inst[19] && !inst[18];
    p_wr = !inst[32] && !inst[31];
    if (inst[3] && inst[2]) viol++;
    if (inst[34:33] != 2'b00 || inst[5:4] != 2'b00) viol++;
    if (x_wr) viol++;
    if (p_wr != rd_prev) viol++;
    if (inst[6] && !v_at_edge) viol++;
    if (x_rd) xq.push_back(inst[17:7]);
    if (p_wr) pq.push_back(inst[30:20]);
    if (inst[6]) rd_n++;
    if (done) done_n++;
    if (busy) busy_n++;
    rd_prev = inst[6];
  end

  task automatic run_pass(input logic [10:0] w, input logic [10:0] x,
                          input logic [10:0] p, input logic [10:0] n,
                          input bit poke, input bit bp, input int exp_lat);
    int d0, b0, r0, xs, ps, lat, cyc;
    logic [10:0] e;
    bit seen;
    d0 = done_n; b0 = busy_n; r0 = rd_n; xs = xq.size(); ps = pq.size();
    @(negedge clk); #1;
    w_base = w; x_base = x; p_base = p; len = n; start = 1'b1; ofifo_valid = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    w_base = 11'h555; x_base = 11'h2AA; p_base = 11'h111; len = 11'h7FF;
    seen = 1'b0;
    for (cyc = 0; cyc < 3000 && !seen; cyc++) begin
      start = poke && (cyc == 20);
      ofifo_valid = bp ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk); #1;
      if (done_n != d0) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    start = 1'b0;
    ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    lat = busy_n - b0;
    check("done_count", done_n - d0, 1);
    check("busy_after", busy, 0);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    else check("stalled", lat > 62, 1);
    check("x_reads", xq.size() - xs, 8 + n);
    for (int i = 0; i < 8 + n; i++) begin
      e = (i < 8) ? w + 11'(i) : x + 11'(i - 8);
      if (xq.size() > xs + i) check("x_addr", xq[xs + i], e);
    end
    check("ofifo_rds", rd_n - r0, n);
    check("p_writes", pq.size() - ps, n);
    for (int i = 0; i < n; i++) begin
      e = p + 11'(i);
      if (pq.size() > ps + i) check("p_addr", pq[ps + i], e);
    end
  endtask

  typedef struct {
    logic [10:0] w, x, p, n;
    bit          poke;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{11'h000, 11'h010, 11'h020, 11'd36, 1'b0, 152};
    vecs[1] = '{11'h100, 11'h7FE, 11'h7FF, 11'd4,  1'b0, 56};
    vecs[2] = '{11'h0A0, 11'h123, 11'h456, 11'd0,  1'b0, 26};
    vecs[3] = '{11'h3F8, 11'h200, 11'h100, 11'd10, 1'b1, 74};

    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1;
    w_base = '0; x_base = '0; p_base = '0; len = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_inst", inst, IDLE_WORD);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++)
      run_pass(vecs[i].w, vecs[i].x, vecs[i].p, vecs[i].n, vecs[i].poke, 1'b0, vecs[i].exp_lat);

    // DRAIN back-pressure: valid pattern 1,0,0 repeating
    run_pass(11'h050, 11'h060, 11'h070, 11'd6, 1'b0, 1'b1, -1);

    // Reset asserted mid-EXEC, then a clean pass
    begin
      bit in_exec;
      @(negedge clk); #1;
      w_base = 11'h010; x_base = 11'h020; p_base = 11'h030; len = 11'd8; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      in_exec = 1'b0;
      for (int c = 0; c < 200 && !in_exec; c++) begin
        @(negedge clk); #1;
        if (inst[1:0] == 2'b10) in_exec = 1'b1;
      end
      check("reach_exec", in_exec, 1);
      #2 reset = 1'b0;
      #1;
      check("midrst_inst", inst, IDLE_WORD);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(negedge clk); #1;
      reset = 1'b1;
      run_pass(11'h200, 11'h300, 11'h400, 11'd4, 1'b0, 1'b0, 56);
    end

    check("protocol_viol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
